time_unit_counter: RTL and testbench

- Generic modulo-N time-unit counter (seconds/minutes/hours) for the digital clock chain; replaces the fixed mod-60 minute/second counters.
- Advances on a rising edge of the lower stage's carry; emits a one-cycle carry pulse on wrap.
- Supports push-button up/down adjust and a hold input.
- Drives two 7-segment digits (tens, ones) directly.

---
 rtl/time_unit_counter.sv | 181 ++++++++++++++++++
 tb/tb_time_unit_counter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/time_unit_counter.sv
// Modulo-N time-unit counter with tick carry chain, push-button adjust and 7-segment decode.
// Optional adjust auto-repeat is compiled in when AUTO_REPEAT_EN is defined.
module time_unit_counter #(
    parameter int unsigned MODULO     = 60,
    parameter int unsigned RESET_VAL  = 59,
    parameter int unsigned W          = 7,
    parameter int unsigned REPEAT_DLY = 25000000,
    parameter int unsigned REPEAT_PER = 5000000
) (
    input  logic         clk50,
    input  logic         reset,
    input  logic         tick_in,
    input  logic         hold,
    input  logic         adj_n,
    input  logic         adj_up,
    output logic [W-1:0] count,
    output logic         carry_out,
    output logic [3:0]   bcd_tens,
    output logic [3:0]   bcd_ones,
    output logic [6:0]   seg_tens,
    output logic [6:0]   seg_ones
);

    localparam logic [W-1:0] MAX_V = W'(MODULO - 1);
    localparam logic [W-1:0] RST_V = W'(RESET_VAL);

    logic         tick_q;
    logic         tick_pend;
    logic         adj_s1;
    logic         adj_s2;
    logic         adj_d;
    logic         tick_ev;
    logic         press_ev;
    logic         rep_ev;
    logic         adj_ev;
    logic [W-1:0] count_inc;
    logic [W-1:0] count_dec;
    logic [W-1:0] count_nxt;
    logic         carry_nxt;
    logic         pend_nxt;
    logic [7:0]   cnt8;

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            tick_q <= 1'b0;
            adj_s1 <= 1'b1;
            adj_s2 <= 1'b1;
            adj_d  <= 1'b1;
        end else begin
            tick_q <= tick_in;
            adj_s1 <= adj_n;
            adj_s2 <= adj_s1;
            adj_d  <= adj_s2;
        end
    end

    assign tick_ev  = tick_in & ~tick_q & ~hold;
    assign press_ev = adj_d & ~adj_s2;
    assign adj_ev   = press_ev | rep_ev;

`ifdef AUTO_REPEAT_EN
    typedef enum logic [1:0] {
        REP_IDLE,
        REP_DELAY,
        REP_REPEAT
    } rep_state_t;

    rep_state_t  rep_state;
    rep_state_t  rep_state_nxt;
    logic [31:0] rep_cnt;
    logic [31:0] rep_cnt_nxt;

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            rep_state <= REP_IDLE;
            rep_cnt   <= '0;
        end else begin
            rep_state <= rep_state_nxt;
            rep_cnt   <= rep_cnt_nxt;
        end
    end

    // rep_cnt equals the number of low cycles since the press (or last repeat).
    always_comb begin
        rep_state_nxt = rep_state;
        rep_cnt_nxt   = rep_cnt;
        rep_ev        = 1'b0;
        if (adj_s2) begin
            rep_state_nxt = REP_IDLE;
            rep_cnt_nxt   = '0;
        end else begin
            case (rep_state)
                REP_IDLE: begin
                    rep_state_nxt = REP_DELAY;
                    rep_cnt_nxt   = 32'd1;
                end
                REP_DELAY: begin
                    if (rep_cnt == REPEAT_DLY) begin
                        rep_ev        = 1'b1;
                        rep_state_nxt = REP_REPEAT;
                        rep_cnt_nxt   = 32'd1;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 32'd1;
                    end
                end
                REP_REPEAT: begin
                    if (rep_cnt == REPEAT_PER) begin
                        rep_ev      = 1'b1;
                        rep_cnt_nxt = 32'd1;
                    end else begin
                        rep_cnt_nxt = rep_cnt + 32'd1;
                    end
                end
                default: begin
                    rep_state_nxt = REP_IDLE;
                    rep_cnt_nxt   = '0;
                end
            endcase
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DLY, REPEAT_PER};
    assign rep_ev        = 1'b0;
`endif

    assign count_inc = (count == MAX_V) ? '0 : count + W'(1);
    assign count_dec = (count == '0) ? MAX_V : count - W'(1);

    // Adjust wins a collision; the tick is parked and applied on the next adjust-free cycle.
    always_comb begin
        count_nxt = count;
        carry_nxt = 1'b0;
        pend_nxt  = tick_pend;
        if (adj_ev) begin
            count_nxt = adj_up ? count_inc : count_dec;
            if (tick_ev) begin
                pend_nxt = 1'b1;
            end
        end else if (tick_ev || tick_pend) begin
            count_nxt = count_inc;
            carry_nxt = (count == MAX_V);
            pend_nxt  = 1'b0;
        end
    end

    always_ff @(posedge clk50 or negedge reset) begin
        if (!reset) begin
            count     <= RST_V;
            carry_out <= 1'b0;
            tick_pend <= 1'b0;
        end else begin
            count     <= count_nxt;
            carry_out <= carry_nxt;
            tick_pend <= pend_nxt;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h40;
            4'd1:    seg7 = 7'h79;
            4'd2:    seg7 = 7'h24;
            4'd3:    seg7 = 7'h30;
            4'd4:    seg7 = 7'h19;
            4'd5:    seg7 = 7'h12;
            4'd6:    seg7 = 7'h02;
            4'd7:    seg7 = 7'h78;
            4'd8:    seg7 = 7'h00;
            4'd9:    seg7 = 7'h10;
            default: seg7 = 7'h7F;
        endcase
    endfunction

    assign cnt8     = 8'(count);
    assign bcd_tens = 4'(cnt8 / 8'd10);
    assign bcd_ones = 4'(cnt8 % 8'd10);
    assign seg_tens = seg7(bcd_tens);
    assign seg_ones = seg7(bcd_ones);

endmodule

// File: tb/tb_time_unit_counter.sv
// Scoreboard bench for time_unit_counter: table of tick/adjust ops plus collision, hold, wrap and reset sequences.
// The auto-repeat sequence is included only when AUTO_REPEAT_EN is defined.
module tb_time_unit_counter;

    logic       clk50   = 1'b0;
    logic       reset   = 1'b0;
    logic       tick_in = 1'b0;
    logic       hold    = 1'b0;
    logic       adj_n   = 1'b1;
    logic       adj_up  = 1'b1;
    logic [6:0] count;
    logic       carry_out;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic [6:0] seg_tens;
    logic [6:0] seg_ones;

    logic       tick24  = 1'b0;
    logic       hold24  = 1'b0;
    logic       adj24_n = 1'b1;
    logic       up24    = 1'b1;
    logic [4:0] count24;
    logic       carry24;
    logic [3:0] bt24;
    logic [3:0] bo24;
    logic [6:0] st24;
    logic [6:0] so24;

    time_unit_counter #(
        .MODULO(60), .RESET_VAL(59), .W(7), .REPEAT_DLY(100), .REPEAT_PER(20)
    ) u_dut (
        .clk50(clk50), .reset(reset), .tick_in(tick_in), .hold(hold),
        .adj_n(adj_n), .adj_up(adj_up), .count(count), .carry_out(carry_out),
        .bcd_tens(bcd_tens), .bcd_ones(bcd_ones), .seg_tens(seg_tens), .seg_ones(seg_ones)
    );

    time_unit_counter #(
        .MODULO(24), .RESET_VAL(0), .W(5), .REPEAT_DLY(100), .REPEAT_PER(20)
    ) u_dut24 (
        .clk50(clk50), .reset(reset), .tick_in(tick24), .hold(hold24),
        .adj_n(adj24_n), .adj_up(up24), .count(count24), .carry_out(carry24),
        .bcd_tens(bt24), .bcd_ones(bo24), .seg_tens(st24), .seg_ones(so24)
    );

    always #10 clk50 = ~clk50;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int carries24 = 0;
    int m     = 59;

    always @(posedge clk50) cyc <= cyc + 1;
    always @(posedge clk50) if (carry24 === 1'b1) carries24 <= carries24 + 1;

    typedef struct {
        int    due;
        string name;
        int    cnt;
        bit    carry;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    localparam int K_TICK = 0;
    localparam int K_ADJ  = 1;
    localparam int K_HOLD = 2;

    typedef struct {
        int kind;
        bit up;
        int exp_cnt;
        bit exp_carry;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    task automatic push(input int due, input string name, input int cnt, input bit carry);
        exp_t x;
        x.due = due; x.name = name; x.cnt = cnt; x.carry = carry;
        sbq.push_back(x);
    endtask

    always @(negedge clk50) begin
        while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            if (e.due < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: expectation for cycle %0d missed at %0d", e.name, e.due, cyc);
            end else begin
                chk({e.name, ".count"}, 32'(count), 32'(e.cnt));
                chk({e.name, ".carry"}, 32'(carry_out), 32'(e.carry));
                chk({e.name, ".bcd_tens"}, 32'(bcd_tens), 32'(e.cnt / 10));
                chk({e.name, ".bcd_ones"}, 32'(bcd_ones), 32'(e.cnt % 10));
                chk({e.name, ".seg_tens"}, 32'(seg_tens), 32'(seg_of(e.cnt / 10)));
                chk({e.name, ".seg_ones"}, 32'(seg_ones), 32'(seg_of(e.cnt % 10)));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk50);
        #1;
    endtask

    task automatic do_tick(input string name, input int want, input bit want_carry);
        int c = cyc;
        push(c, {name, ".pre"}, m, 1'b0);
        tick_in = 1'b1;
        push(c + 1, name, want, want_carry);
        push(c + 2, {name, ".post"}, want, 1'b0);
        step(10);
        tick_in = 1'b0;
        step(2);
        m = want;
    endtask

    task automatic do_adj(input string name, input bit up, input int want);
        int c = cyc;
        adj_up = up;
        adj_n  = 1'b0;
        push(c + 2, {name, ".pre"}, m, 1'b0);
        push(c + 3, name, want, 1'b0);
        push(c + 4, {name, ".post"}, want, 1'b0);
        step(6);
        adj_n = 1'b1;
        push(cyc + 4, {name, ".release"}, want, 1'b0);
        step(6);
        m = want;
    endtask

    task automatic do_hold_ticks(input string name);
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(cyc + 1, name, m, 1'b0);
            tick_in = 1'b1;
            step(3);
            tick_in = 1'b0;
            step(2);
        end
        hold = 1'b0;
        push(cyc + 2, {name, ".backlog"}, m, 1'b0);
        step(4);
    endtask

    // Adjust event and tick edge land on the same clock edge.
    task automatic do_collide(input string name, input bit up);
        int c = cyc;
        int a = up ? (m + 1) % 60 : (m + 59) % 60;
        int b = (a + 1) % 60;
        adj_up = up;
        adj_n  = 1'b0;
        step(2);
        tick_in = 1'b1;
        push(c + 3, {name, ".adj"}, a, 1'b0);
        push(c + 4, {name, ".pend"}, b, a == 59);
        push(c + 5, {name, ".post"}, b, 1'b0);
        step(5);
        tick_in = 1'b0;
        adj_n   = 1'b1;
        step(6);
        m = b;
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 50) begin
            step(1);
            n++;
        end
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations never reached", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        vecs[0] = '{K_TICK, 1'b0, 0,  1'b1};
        vecs[1] = '{K_TICK, 1'b0, 1,  1'b0};
        vecs[2] = '{K_ADJ,  1'b0, 0,  1'b0};
        vecs[3] = '{K_ADJ,  1'b0, 59, 1'b0};
        vecs[4] = '{K_ADJ,  1'b1, 0,  1'b0};
        vecs[5] = '{K_ADJ,  1'b1, 1,  1'b0};
        vecs[6] = '{K_HOLD, 1'b0, 1,  1'b0};
        vecs[7] = '{K_TICK, 1'b0, 2,  1'b0};

        step(3);
        chk("reset.count", 32'(count), 32'd59);
        chk("reset.carry", 32'(carry_out), 32'd0);
        chk("reset.seg_tens", 32'(seg_tens), 32'h12);
        chk("reset.seg_ones", 32'(seg_ones), 32'h10);
        chk("reset.count24", 32'(count24), 32'd0);
        reset = 1'b1;
        step(3);

        for (int i = 0; i < 8; i++) begin
            case (vecs[i].kind)
                K_TICK:  do_tick($sformatf("vec%0d.tick", i), vecs[i].exp_cnt, vecs[i].exp_carry);
                K_ADJ:   do_adj($sformatf("vec%0d.adj", i), vecs[i].up, vecs[i].exp_cnt);
                default: do_hold_ticks($sformatf("vec%0d.hold", i));
            endcase
        end
        drain();

        while (m != 10) do_tick("walk", (m + 1) % 60, (m == 59));
        do_collide("collide10", 1'b1);
        while (m != 58) do_tick("walk", (m + 1) % 60, (m == 59));
        do_collide("collide58", 1'b1);
        drain();

        for (int i = 0; i < 24; i++) begin
            if (i == 23) begin
                chk("mod24.at23", 32'(count24), 32'd23);
                chk("mod24.nocarry", 32'(carries24), 32'd0);
            end
            tick24 = 1'b1;
            step(2);
            tick24 = 1'b0;
            step(2);
        end
        chk("mod24.wrap", 32'(count24), 32'd0);
        chk("mod24.carries", 32'(carries24), 32'd1);

        // Reset lands after the collision edge, before the parked tick would apply.
        adj_up = 1'b1;
        adj_n  = 1'b0;
        step(2);
        tick_in = 1'b1;
        step(1);
        reset = 1'b0;
        #2;
        chk("rstmid.count", 32'(count), 32'd59);
        chk("rstmid.carry", 32'(carry_out), 32'd0);
        step(2);
        adj_n   = 1'b1;
        tick_in = 1'b0;
        step(2);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("rstmid.stays", 32'(count), 32'd59);
            chk("rstmid.nocarry", 32'(carry_out), 32'd0);
        end
        m = 59;

`ifdef AUTO_REPEAT_EN
        do_tick("rep.zero", 0, 1'b1);
        drain();
        adj_up = 1'b1;
        adj_n  = 1'b0;
        step(160);
        adj_n = 1'b1;
        step(6);
        chk("repeat.count", 32'(count), 32'd4);
        adj_n = 1'b0;
        step(50);
        reset = 1'b0;
        step(2);
        adj_n = 1'b1;
        step(3);
        reset = 1'b1;
        step(200);
        chk("repeat.reset", 32'(count), 32'd59);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
